// File: rtl/mem_stage.sv
// RV32I memory-access stage: data-memory req/gnt/rvalid handshake, load/store lane steering, MEM/WB register.
// Optional macro MEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of issuing them.
package CORE_PKG;
   typedef enum logic [3:0] {
      LSU_LB  = 4'b0000,
      LSU_LH  = 4'b0001,
      LSU_LW  = 4'b0010,
      LSU_LBU = 4'b0100,
      LSU_LHU = 4'b0101,
      LSU_SB  = 4'b1000,
      LSU_SH  = 4'b1001,
      LSU_SW  = 4'b1010
   } load_store_func_code;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_MEM  = 2'd1,
      WB_PC4  = 2'd2,
      WB_UIMM = 2'd3
   } write_back_mux_selector;
endpackage

module mem_stage
   import CORE_PKG::*;
(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   lsu_enable_ip,
   input  load_store_func_code    lsu_operator_ip,
   input  logic [31:0]            alu_result_ip,
   input  logic                   alu_valid_ip,
   input  logic [31:0]            mem_wdata_ip,
   input  write_back_mux_selector wb_mux_ip,
   input  logic [4:0]             write_reg_addr_ip,
   input  logic [31:0]            pc_addr_ip,
   input  logic [31:0]            uimmd_ip,
   output logic                   data_req_op,
   output logic [31:0]            data_addr_op,
   output logic                   data_we_op,
   output logic [3:0]             data_be_op,
   output logic [31:0]            data_wdata_op,
   input  logic                   data_gnt_ip,
   input  logic                   data_rvalid_ip,
   input  logic [31:0]            data_rdata_ip,
   output logic                   stall_op,
   output logic [31:0]            fw_mem_data_op,
   output logic                   misaligned_op,
   output logic                   wb_valid_op,
   output write_back_mux_selector wb_mux_op,
   output logic [4:0]             write_reg_addr_op,
   output logic [31:0]            alu_result_op,
   output logic [31:0]            mem_rdata_op,
   output logic [31:0]            pc_addr_op,
   output logic [31:0]            uimmd_op
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_GNT, S_WAIT_RVALID} state_t;

   state_t                 state_q, state_d;
   logic                   wb_valid_q, wb_valid_d;
   logic                   misaligned_q, misaligned_d;
   write_back_mux_selector wb_mux_q, wb_mux_d;
   logic [4:0]             write_reg_addr_q, write_reg_addr_d;
   logic [31:0]            alu_result_q, alu_result_d;
   logic [31:0]            mem_rdata_q, mem_rdata_d;
   logic [31:0]            pc_addr_q, pc_addr_d;
   logic [31:0]            uimmd_q, uimmd_d;

   logic       access, mis, mem_access, retire;
   logic       is_store, size_byte, size_half;
   logic [1:0] off;
   logic [3:0] be_lanes;

   function automatic logic [31:0] load_extract(input load_store_func_code op,
                                                input logic [1:0] a,
                                                input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[8*a +: 8];
      h = a[1] ? word[31:16] : word[15:0];
      case (op)
         LSU_LB:  return {{24{b[7]}}, b};
         LSU_LBU: return {24'd0, b};
         LSU_LH:  return {{16{h[15]}}, h};
         LSU_LHU: return {16'd0, h};
         default: return word;
      endcase
   endfunction

   assign access     = lsu_enable_ip & alu_valid_ip;
   assign off        = alu_result_ip[1:0];
   assign is_store   = lsu_operator_ip[3];
   assign size_byte  = (lsu_operator_ip == LSU_LB) | (lsu_operator_ip == LSU_LBU) |
                       (lsu_operator_ip == LSU_SB);
   assign size_half  = (lsu_operator_ip == LSU_LH) | (lsu_operator_ip == LSU_LHU) |
                       (lsu_operator_ip == LSU_SH);

`ifdef MEM_MISALIGN_TRAP_EN
   assign mis = access & ((size_half & off[0]) | (~size_byte & ~size_half & (off != 2'b00)));
`else
   assign mis = 1'b0;
`endif

   assign mem_access = access & ~mis;

   // Halfword lanes use only addr[1]; word accesses ignore the low address bits entirely.
   always_comb begin
      be_lanes      = 4'b1111;
      data_wdata_op = mem_wdata_ip;
      if (size_byte) begin
         be_lanes      = 4'b0001 << off;
         data_wdata_op = {4{mem_wdata_ip[7:0]}};
      end else if (size_half) begin
         be_lanes      = off[1] ? 4'b1100 : 4'b0011;
         data_wdata_op = {2{mem_wdata_ip[15:0]}};
      end
   end

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!mem_access) begin
               retire = 1'b1;
            end else if (data_gnt_ip) begin
               if (is_store) retire  = 1'b1;
               else          state_d = S_WAIT_RVALID;
            end else begin
               state_d = S_WAIT_GNT;
            end
         end
         S_WAIT_GNT: begin
            if (data_gnt_ip) begin
               if (is_store) begin
                  retire  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WAIT_RVALID;
               end
            end
         end
         S_WAIT_RVALID: begin
            if (data_rvalid_ip) begin
               retire  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Request and stall are gated by reset so they drop the moment reset asserts.
   assign data_req_op    = reset & mem_access & (state_q != S_WAIT_RVALID);
   assign data_we_op     = data_req_op & is_store;
   assign data_be_op     = data_req_op ? be_lanes : 4'b0000;
   assign data_addr_op   = {alu_result_ip[31:2], 2'b00};
   assign stall_op       = reset & ~retire;
   assign fw_mem_data_op = alu_result_ip;

   always_comb begin
      wb_valid_d       = retire;
      misaligned_d     = retire & mis;
      write_reg_addr_d = (retire & ~mis) ? write_reg_addr_ip : 5'd0;
      wb_mux_d         = wb_mux_ip;
      alu_result_d     = alu_result_ip;
      pc_addr_d        = pc_addr_ip;
      uimmd_d          = uimmd_ip;
      mem_rdata_d      = 32'd0;
      if (retire && (state_q == S_WAIT_RVALID))
         mem_rdata_d = load_extract(lsu_operator_ip, off, data_rdata_ip);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q          <= S_IDLE;
         wb_valid_q       <= 1'b0;
         misaligned_q     <= 1'b0;
         wb_mux_q         <= WB_ALU;
         write_reg_addr_q <= 5'd0;
         alu_result_q     <= 32'd0;
         mem_rdata_q      <= 32'd0;
         pc_addr_q        <= 32'd0;
         uimmd_q          <= 32'd0;
      end else begin
         state_q          <= state_d;
         wb_valid_q       <= wb_valid_d;
         misaligned_q     <= misaligned_d;
         wb_mux_q         <= wb_mux_d;
         write_reg_addr_q <= write_reg_addr_d;
         alu_result_q     <= alu_result_d;
         mem_rdata_q      <= mem_rdata_d;
         pc_addr_q        <= pc_addr_d;
         uimmd_q          <= uimmd_d;
      end
   end

   assign wb_valid_op       = wb_valid_q;
   assign misaligned_op     = misaligned_q;
   assign wb_mux_op         = wb_mux_q;
   assign write_reg_addr_op = write_reg_addr_q;
   assign alu_result_op     = alu_result_q;
   assign mem_rdata_op      = mem_rdata_q;
   assign pc_addr_op        = pc_addr_q;
   assign uimmd_op          = uimmd_q;

endmodule
